// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the chip reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_DEBOUNCE,
    ST_RELEASE,
    ST_RUN,
    ST_SWHOLD
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  // One shared counter serves all three timed phases, so size it for the longest.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop synchronizer with asynchronous active-low clear.
module reset_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values; blocking here would collapse the chain to one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases reset domains in index order after POR, pad reset or a soft-reset request,
// and reports busy status and the cause of the most recent reset entry.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int DEBOUNCE    = 8,
  parameter int STAGE_DELAY = 16,
  parameter int SW_PULSE    = 32
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  ext_resetb,
  input  logic                  sw_reset,
  output logic [NUM_STAGES-1:0] stage_resetb,
  output logic                  seq_busy,
  output logic [1:0]            reset_cause
);

  localparam int CNT_W = cnt_width(DEBOUNCE, STAGE_DELAY, SW_PULSE);
  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_PULSE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  logic             rst_int_n;
  logic             ext_s;
  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  // Block reset asserts asynchronously but leaves reset in step with clk.
  reset_sync u_rst_sync (
    .clk   (clk),
    .rst_n (resetb),
    .d     (1'b1),
    .q     (rst_int_n)
  );

  reset_sync u_ext_sync (
    .clk   (clk),
    .rst_n (resetb),
    .d     (ext_resetb),
    .q     (ext_s)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state        <= ST_HOLD;
      stage_resetb <= '0;
      cnt          <= '0;
      idx          <= '0;
      seq_busy     <= 1'b1;
      reset_cause  <= CAUSE_POR;
    end else if (!ext_s) begin
      // Pad reset outranks a same-cycle soft request; cause only records a new entry.
      stage_resetb <= '0;
      cnt          <= '0;
      idx          <= '0;
      seq_busy     <= 1'b1;
      if (state != ST_HOLD) begin
        state       <= ST_HOLD;
        reset_cause <= CAUSE_EXT;
      end
    end else if (sw_reset && state == ST_RUN) begin
      state        <= ST_SWHOLD;
      stage_resetb <= '0;
      cnt          <= '0;
      idx          <= '0;
      seq_busy     <= 1'b1;
      reset_cause  <= CAUSE_SW;
    end else begin
      case (state)
        ST_HOLD: begin
          stage_resetb <= '0;
          cnt          <= '0;
          state        <= ST_DEBOUNCE;
        end
        ST_DEBOUNCE: begin
          if (cnt == DEB_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == STG_LAST) begin
            cnt          <= '0;
            stage_resetb <= stage_resetb | (NUM_STAGES'(1) << idx);
            if (idx == IDX_LAST) begin
              idx      <= '0;
              state    <= ST_RUN;
              seq_busy <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          cnt <= '0;
          idx <= '0;
        end
        ST_SWHOLD: begin
          stage_resetb <= '0;
          // Soft reset skips debounce: the pad is already known stable.
          if (cnt == SW_LAST) begin
            state <= ST_RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule
